// File: rtl/jtag_tap_pkg.sv
// Shared TAP types: the 16-state controller encoding, data-register selector
// and the standard next-state table.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'h0,
        TAP_RTI      = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SHIFT_DR = 4'h4,
        TAP_EXIT1_DR = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EXIT2_DR = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'hA,
        TAP_SHIFT_IR = 4'hB,
        TAP_EXIT1_IR = 4'hC,
        TAP_PAUSE_IR = 4'hD,
        TAP_EXIT2_IR = 4'hE,
        TAP_UPD_IR   = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    // Instruction value selecting the IDCODE register (zero-extended to IR width)
    localparam int unsigned IR_IDCODE = 32'd1;

    // IEEE 1149.1 TAP controller transition table
    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TAP_TLR:      nxt = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      nxt = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   nxt = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state register. Advances one step per detected TCK rise and
// flags the clk_i cycle right after each step so the datapath can act once on
// state entry (Update-IR, Update-DR, Test-Logic-Reset).
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output logic       entered_o
);

    tap_state_e state_q;
    logic       entered_q;

    // State register: synchronous clear from TRST wins over a coincident advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= TAP_TLR;
            entered_q <= 1'b0;
        end else if (clr_i) begin
            state_q   <= TAP_TLR;
            entered_q <= 1'b0;
        end else if (adv_i) begin
            state_q   <= tap_next(state_q, tms_i);
            entered_q <= 1'b1;
        end else begin
            entered_q <= 1'b0;
        end
    end

    assign state_o   = state_q;
    assign entered_o = entered_q;

endmodule

// File: rtl/jtag_tap_sampled.sv
// Oversampled JTAG TAP: TCK/TMS/TDI/TRST_n are synchronised into clk_i and
// TCK edges are detected, so all IR/DR/TDO logic runs on the system clock.
module jtag_tap_sampled
    import jtag_tap_pkg::*;
#(
    parameter int unsigned        IrWidth     = 5,
    parameter logic [31:0]        IdcodeValue = 32'h0000_0001,
    parameter logic [IrWidth-1:0] UserIr      = IrWidth'(5'h11),
    parameter int unsigned        UserDrWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   jtag_tck_i,
    input  logic                   jtag_tms_i,
    input  logic                   jtag_tdi_i,
    input  logic                   jtag_trst_ni,
    output logic                   jtag_tdo_o,
    output logic                   jtag_tdo_oe_o,
    output logic [IrWidth-1:0]     ir_o,
    input  logic [UserDrWidth-1:0] user_capture_data_i,
    output logic                   user_update_o,
    output logic [UserDrWidth-1:0] user_update_data_o
);

    localparam logic [IrWidth-1:0] IrIdcode  = IrWidth'(IR_IDCODE);
    localparam logic [IrWidth-1:0] IrCapture = IrWidth'(2'b01);

    logic tck_meta_q, tck_sync_q, tck_q;
    logic tms_meta_q, tms_sync_q;
    logic tdi_meta_q, tdi_sync_q;
    logic trst_meta_q, trst_sync_q;

    logic       tck_rise_s, tck_fall_s, trst_s;
    tap_state_e state_s;
    logic       entered_s;
    dr_sel_e    dr_sel_s;
    logic       dr_lsb_s;

    logic [IrWidth-1:0]     ir_q, ir_sr_q, ir_sr_shift_s;
    logic [31:0]            idcode_dr_q;
    logic                   bypass_q;
    logic [UserDrWidth-1:0] user_dr_q, user_dr_shift_s, user_upd_data_q;
    logic                   user_upd_q, tdo_q, tdo_oe_q;

    // Two-flop synchronisers for all pins plus a third TCK flop for edge detect;
    // TRST sync resets asserted so the TAP stays cleared until it is seen released
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_meta_q  <= 1'b0;
            tck_sync_q  <= 1'b0;
            tck_q       <= 1'b0;
            tms_meta_q  <= 1'b0;
            tms_sync_q  <= 1'b0;
            tdi_meta_q  <= 1'b0;
            tdi_sync_q  <= 1'b0;
            trst_meta_q <= 1'b0;
            trst_sync_q <= 1'b0;
        end else begin
            tck_meta_q  <= jtag_tck_i;
            tck_sync_q  <= tck_meta_q;
            tck_q       <= tck_sync_q;
            tms_meta_q  <= jtag_tms_i;
            tms_sync_q  <= tms_meta_q;
            tdi_meta_q  <= jtag_tdi_i;
            tdi_sync_q  <= tdi_meta_q;
            trst_meta_q <= jtag_trst_ni;
            trst_sync_q <= trst_meta_q;
        end
    end

    // Edge strobes, shift-right next values and data-register selection
    always_comb begin
        tck_rise_s = tck_sync_q & ~tck_q;
        tck_fall_s = ~tck_sync_q & tck_q;
        trst_s     = ~trst_sync_q;

        ir_sr_shift_s                  = ir_sr_q >> 1'b1;
        ir_sr_shift_s[IrWidth-1]       = tdi_sync_q;
        user_dr_shift_s                = user_dr_q >> 1'b1;
        user_dr_shift_s[UserDrWidth-1] = tdi_sync_q;

        if (ir_q == IrIdcode) begin
            dr_sel_s = DR_IDCODE;
        end else if (ir_q == UserIr) begin
            dr_sel_s = DR_USER;
        end else begin
            dr_sel_s = DR_BYPASS;
        end

        case (dr_sel_s)
            DR_IDCODE: dr_lsb_s = idcode_dr_q[0];
            DR_USER:   dr_lsb_s = user_dr_q[0];
            default:   dr_lsb_s = bypass_q;
        endcase
    end

    jtag_tap_fsm u_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (trst_s),
        .adv_i     (tck_rise_s),
        .tms_i     (tms_sync_q),
        .state_o   (state_s),
        .entered_o (entered_s)
    );

    // Datapath: capture/shift on TCK rise (using the pre-transition state),
    // update on state entry, TDO/OE on TCK fall; TRST clears like reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_q            <= IrIdcode;
            ir_sr_q         <= '0;
            idcode_dr_q     <= 32'h0000_0000;
            bypass_q        <= 1'b0;
            user_dr_q       <= '0;
            user_upd_data_q <= '0;
            user_upd_q      <= 1'b0;
            tdo_q           <= 1'b0;
            tdo_oe_q        <= 1'b0;
        end else if (trst_s) begin
            ir_q            <= IrIdcode;
            ir_sr_q         <= '0;
            idcode_dr_q     <= 32'h0000_0000;
            bypass_q        <= 1'b0;
            user_dr_q       <= '0;
            user_upd_data_q <= '0;
            user_upd_q      <= 1'b0;
            tdo_q           <= 1'b0;
            tdo_oe_q        <= 1'b0;
        end else begin
            user_upd_q <= 1'b0;

            if (tck_rise_s) begin
                case (state_s)
                    TAP_CAP_IR:   ir_sr_q <= IrCapture;
                    TAP_SHIFT_IR: ir_sr_q <= ir_sr_shift_s;
                    TAP_CAP_DR: begin
                        idcode_dr_q <= IdcodeValue;
                        bypass_q    <= 1'b0;
                        user_dr_q   <= user_capture_data_i;
                    end
                    TAP_SHIFT_DR: begin
                        case (dr_sel_s)
                            DR_IDCODE: idcode_dr_q <= {tdi_sync_q, idcode_dr_q[31:1]};
                            DR_USER:   user_dr_q   <= user_dr_shift_s;
                            default:   bypass_q    <= tdi_sync_q;
                        endcase
                    end
                    default: ;
                endcase
            end

            if (entered_s) begin
                case (state_s)
                    TAP_TLR:    ir_q <= IrIdcode;
                    TAP_UPD_IR: ir_q <= ir_sr_q;
                    TAP_UPD_DR: begin
                        if (dr_sel_s == DR_USER) begin
                            user_upd_data_q <= user_dr_q;
                            user_upd_q      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (tck_fall_s) begin
                if (state_s == TAP_SHIFT_IR) begin
                    tdo_q    <= ir_sr_q[0];
                    tdo_oe_q <= 1'b1;
                end else if (state_s == TAP_SHIFT_DR) begin
                    tdo_q    <= dr_lsb_s;
                    tdo_oe_q <= 1'b1;
                end else begin
                    tdo_oe_q <= 1'b0;
                end
            end
        end
    end

    assign jtag_tdo_o         = tdo_q;
    assign jtag_tdo_oe_o      = tdo_oe_q;
    assign ir_o               = ir_q;
    assign user_update_o      = user_upd_q;
    assign user_update_data_o = user_upd_data_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: TCK is bit-banged from the system clock,
// expected TDO bits and update words go through scoreboard queues.
module tb_jtag_tap_sampled;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tck = 1'b0;
    logic        tms = 1'b0;
    logic        tdi = 1'b0;
    logic        trst_n = 1'b1;
    logic        tdo, tdo_oe, upd;
    logic [4:0]  ir;
    logic [31:0] cap_data = 32'h0000_0000;
    logic [31:0] upd_data;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;
    int half = 2;

    logic        tdo_exp_q[$];
    logic [31:0] upd_exp_q[$];

    always #5 clk = ~clk;

    jtag_tap_sampled dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .jtag_tck_i          (tck),
        .jtag_tms_i          (tms),
        .jtag_tdi_i          (tdi),
        .jtag_trst_ni        (trst_n),
        .jtag_tdo_o          (tdo),
        .jtag_tdo_oe_o       (tdo_oe),
        .ir_o                (ir),
        .user_capture_data_i (cap_data),
        .user_update_o       (upd),
        .user_update_data_o  (upd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Update-pulse monitor: every high cycle must match one queued expectation
    always @(negedge clk) begin
        if (upd === 1'b1) begin
            upd_cnt++;
            tests++;
            assert (upd_exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_update observed=%h expected=none", upd_data);
            end
            if (upd_exp_q.size() > 0) check("upd_data_at_pulse", upd_data, upd_exp_q.pop_front());
        end
    end

    // One TCK period; returns TDO/OE as presented after the previous falling edge
    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic oe_v);
        tms = tms_v;
        tdi = tdi_v;
        tck = 1'b1;
        repeat (half) @(negedge clk);
        tdo_v = tdo;
        oe_v  = tdo_oe;
        tck = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic tms_seq(input int n, input logic [7:0] bits);
        logic o, oe;
        for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'b0, o, oe);
    endtask

    task automatic goto_shift_dr();
        tms_seq(3, 8'b0000_0001);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] din, input logic [31:0] dexp, input logic exit_last);
        logic o, oe;
        for (int i = 0; i < n; i++) begin
            tdo_exp_q.push_back(dexp[i]);
            tck_cycle(exit_last && (i == n - 1), din[i], o, oe);
            check("dr_tdo", 32'(o), 32'(tdo_exp_q.pop_front()));
            if (i == 0) check("dr_tdo_oe", 32'(oe), 32'd1);
        end
    endtask

    task automatic exit_update(input logic expect_pulse, input logic [31:0] d);
        if (expect_pulse) upd_exp_q.push_back(d);
        tms_seq(2, 8'b0000_0001);
        repeat (4) @(negedge clk);
    endtask

    task automatic load_ir(input logic [4:0] v);
        logic o, oe;
        tms_seq(4, 8'b0000_0011);
        for (int i = 0; i < 5; i++) begin
            tdo_exp_q.push_back(i == 0);
            tck_cycle(i == 4, v[i], o, oe);
            check("ir_capture_tdo", 32'(o), 32'(tdo_exp_q.pop_front()));
            if (i == 0) check("ir_tdo_oe", 32'(oe), 32'd1);
        end
        tms_seq(2, 8'b0000_0001);
        repeat (4) @(negedge clk);
        check("ir_after_update", 32'(ir), 32'(v));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ir"}, 32'(ir), 32'h0000_0001);
        check({tag, "_tdo_oe"}, 32'(tdo_oe), 32'd0);
        check({tag, "_tdo"}, 32'(tdo), 32'd0);
        check({tag, "_upd_data"}, upd_data, 32'h0000_0000);
        check({tag, "_upd"}, 32'(upd), 32'd0);
    endtask

    task automatic run_all(input int h);
        int c0;
        half = h;
        c0 = upd_cnt;
        tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst_n = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        // Load a non-IDCODE IR, then TRST must restore IDCODE
        tms_seq(1, 8'b0000_0000);
        load_ir(5'h1F);
        trst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("trst_ir", 32'(ir), 32'h0000_0001);
        check("trst_tdo_oe", 32'(tdo_oe), 32'd0);
        trst_n = 1'b1;
        repeat (3) @(negedge clk);
        tms_seq(5, 8'b0001_1111);
        check("tlr_ir", 32'(ir), 32'h0000_0001);
        check("tlr_tdo_oe", 32'(tdo_oe), 32'd0);

        // IDCODE read
        tms_seq(1, 8'b0000_0000);
        goto_shift_dr();
        shift_dr(32, 32'h0000_0000, 32'h0000_0001, 1'b1);
        exit_update(1'b0, 32'h0);

        // BYPASS with all-ones IR: one leading zero, then data delayed one bit
        load_ir(5'h1F);
        goto_shift_dr();
        shift_dr(9, 32'h0000_00A5, 32'h0000_014A, 1'b1);
        exit_update(1'b0, 32'h0);
        check("bypass_no_pulse", 32'(upd_cnt), 32'(c0));

        // User DR capture/shift/update
        load_ir(5'h11);
        cap_data = 32'hDEAD_BEEF;
        goto_shift_dr();
        shift_dr(32, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
        exit_update(1'b1, 32'h1234_5678);
        check("user_pulse_count", 32'(upd_cnt), 32'(c0 + 1));
        check("user_upd_data", upd_data, 32'h1234_5678);

        // Exit1 -> Pause -> Exit2 -> Shift keeps contents, no pulse until Update-DR
        cap_data = 32'hCAFE_F00D;
        goto_shift_dr();
        shift_dr(16, 32'h0000_C0DE, 32'h0000_F00D, 1'b1);
        tms_seq(4, 8'b0000_0100);
        check("pause_no_pulse", 32'(upd_cnt), 32'(c0 + 1));
        shift_dr(16, 32'h0000_0BAD, 32'h0000_CAFE, 1'b1);
        exit_update(1'b1, 32'h0BAD_C0DE);
        check("pause_pulse_count", 32'(upd_cnt), 32'(c0 + 2));
        check("pause_upd_data", upd_data, 32'h0BAD_C0DE);

        // Non-user IR Update-DR gives no pulse
        load_ir(5'h03);
        goto_shift_dr();
        shift_dr(4, 32'h0000_0005, 32'h0000_000A, 1'b1);
        exit_update(1'b0, 32'h0);
        check("other_ir_no_pulse", 32'(upd_cnt), 32'(c0 + 2));

        // rst_i in the middle of a user Shift-DR
        load_ir(5'h11);
        goto_shift_dr();
        shift_dr(10, 32'h0000_03FF, 32'hCAFE_F00D, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_shift_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("after_rst");
        check("rst_no_pulse", 32'(upd_cnt), 32'(c0 + 2));
        // One TMS=0 step from Test-Logic-Reset lands in Run-Test/Idle
        tms_seq(1, 8'b0000_0000);
        goto_shift_dr();
        shift_dr(32, 32'h0000_0000, 32'h0000_0001, 1'b1);
        exit_update(1'b0, 32'h0);
        check("final_pulse_count", 32'(upd_cnt), 32'(c0 + 2));
    endtask

    initial begin
        run_all(2);
        run_all(4);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(upd_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
